// File: rtl/riscky_pkg.sv
// riscky_pkg: shared core-wide definitions.
//   XLEN / ILEN    : address and instruction widths.
//   fetch_state_t  : fetch sequencer states.
//   fetch_entry_t  : one IF/ID buffer entry (fetch PC + instruction word).
package riscky_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DRAIN
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: instruction memory request/response port.
//   imem_req_valid / imem_req_addr : fetch request (fetch -> memory)
//   imem_req_ready                 : memory accepts the request this cycle
//   imem_rsp_valid / imem_rsp_instr: in-order response, one per accepted request
// Modports: master = fetch side, slave = memory side.
interface fetch_ctrl_if;

    logic                       imem_req_valid;
    logic [riscky_pkg::XLEN-1:0] imem_req_addr;
    logic                       imem_req_ready;
    logic                       imem_rsp_valid;
    logic [riscky_pkg::ILEN-1:0] imem_rsp_instr;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_instr
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_instr
    );

endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: small FIFO of fetch_entry_t with a registered head.
//   clk, rst  : clock, asynchronous active-high reset
//   push      : write push_data at the tail (ignored when full without pop)
//   pop       : drop the head entry (ignored when empty)
//   flush     : empty the FIFO; overrides push and pop in the same cycle
//   count     : number of valid entries
//   head      : registered head entry; holds its last value while empty
module fetch_fifo
    import riscky_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  fetch_entry_t               push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output fetch_entry_t               head
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    fetch_entry_t   mem [DEPTH];
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  wr_ptr;
    logic [CW-1:0]  count_q;
    fetch_entry_t   head_q;

    logic           do_push;
    logic           do_pop;
    logic [PW-1:0]  rd_ptr_next;
    logic [CW-1:0]  count_next;
    fetch_entry_t   head_next;

    // The head is re-registered from whatever entry will sit at the read
    // pointer after this cycle. If that slot is the one being written right
    // now, the incoming data bypasses storage.
    always_comb begin
        do_pop      = pop && (count_q != '0);
        do_push     = push && ((count_q != CW'(DEPTH)) || do_pop);
        rd_ptr_next = rd_ptr + PW'(do_pop);
        count_next  = count_q + CW'(do_push) - CW'(do_pop);
        head_next   = (do_push && (wr_ptr == rd_ptr_next)) ? push_data : mem[rd_ptr_next];
    end

    // Storage array carries no reset; only slots covered by count are read.
    always_ff @(posedge clk) begin
        if (!rst && do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two. The head
    // register only loads when the FIFO will be non-empty, so it keeps its
    // last value across an empty period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
            head_q  <= '0;
        end else if (flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            rd_ptr  <= rd_ptr_next;
            wr_ptr  <= wr_ptr + PW'(do_push);
            count_q <= count_next;
            if (count_next != '0) begin
                head_q <= head_next;
            end
        end
    end

    assign count = count_q;
    assign head  = head_q;

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch-stage sequencer. Owns the PC, issues one outstanding
// request at a time to the instruction memory and buffers responses in the
// IF/ID FIFO.
//   clk, rst     : clock, asynchronous active-high reset
//   pc_src_e     : redirect from execute; pc_target_e is the target
//   stall_d      : decode holds the head entry
//   imem         : instruction memory port (fetch_ctrl_if.master)
//   instr_d, pc_d, pc_plus4_d, valid_d : IF/ID head entry to decode
module fetch_ctrl
    import riscky_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pc_src_e,
    input  logic [XLEN-1:0]  pc_target_e,
    input  logic             stall_d,
    fetch_ctrl_if.master     imem,
    output logic [ILEN-1:0]  instr_d,
    output logic [XLEN-1:0]  pc_d,
    output logic [XLEN-1:0]  pc_plus4_d,
    output logic             valid_d
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    fetch_state_t   state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] req_pc;
    logic           head_seen_q;

    logic [CW-1:0]  fifo_count;
    fetch_entry_t   fifo_head;
    fetch_entry_t   push_entry;
    logic           req_fire;
    logic           rsp_fire;
    logic           push;
    logic           pop;
    logic           unused_target_lsbs;

    // Redirect targets are word aligned; the low bits are ignored.
    assign unused_target_lsbs = ^pc_target_e[1:0];

    // A request is only offered when the FIFO has room for its response,
    // so a response in WAIT can always be pushed.
    assign imem.imem_req_valid = (state == REQ) && (fifo_count < CW'(FIFO_DEPTH));
    assign imem.imem_req_addr  = (state == IDLE) ? '0 : pc;

    // A redirect cancels any push of a wrong-path response and any pop
    // of the head, since the whole buffer is flushed that cycle.
    always_comb begin
        req_fire         = imem.imem_req_valid && imem.imem_req_ready;
        rsp_fire         = (state == WAIT) && imem.imem_rsp_valid;
        push             = rsp_fire && !pc_src_e;
        pop              = valid_d && !stall_d && !pc_src_e;
        push_entry.pc    = req_pc;
        push_entry.instr = imem.imem_rsp_instr;
    end

    // Sequencer. DRAIN exists to swallow the single response still owed
    // for a request that was accepted before a redirect took effect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            pc     <= RESET_PC;
            req_pc <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state <= REQ;
                end
                REQ: begin
                    if (req_fire) begin
                        req_pc <= pc;
                        state  <= pc_src_e ? DRAIN : WAIT;
                    end
                end
                WAIT: begin
                    if (imem.imem_rsp_valid) begin
                        state <= REQ;
                    end else if (pc_src_e) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (imem.imem_rsp_valid) begin
                        state <= REQ;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if (pc_src_e) begin
                pc <= {pc_target_e[XLEN-1:2], 2'b00};
            end else if (req_fire) begin
                pc <= pc + XLEN'(4);
            end
        end
    end

    // pc_plus4_d reads 0 out of reset until the first entry has reached the
    // head; afterwards it always tracks the (possibly stale) head PC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_seen_q <= 1'b0;
        end else if (valid_d) begin
            head_seen_q <= 1'b1;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (pc_src_e),
        .count     (fifo_count),
        .head      (fifo_head)
    );

    assign valid_d    = (fifo_count != '0);
    assign instr_d    = fifo_head.instr;
    assign pc_d       = fifo_head.pc;
    assign pc_plus4_d = (head_seen_q || valid_d) ? (fifo_head.pc + XLEN'(4)) : '0;

endmodule
